quad_decoder: RTL

Sequential decoder for a 2-bit Gray-code (quadrature) rotary encoder on the board's A/B pins. It synchronises and debounces the raw phase inputs, tracks the Gray phase sequence, and maintains a wrap-around position count in both binary and Gray form for LED display. This is the receive-side counterpart to the team's Gray-code generation and conversion logic: it consumes a Gray sequence instead of producing one.

---
 rtl/quad_decoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// quad_decoder: synchronises and debounces a 2-bit quadrature (Gray) encoder,
// decodes forward/reverse/illegal phase changes, and keeps a wrapping position
// count in binary and Gray form plus a saturating illegal-change counter.
module quad_decoder #(
  parameter int CNT_W     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic [CNT_W-1:0] pos,
  output logic [CNT_W-1:0] pos_gray,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [3:0]       err_cnt
);

  // Debounce counter only needs to reach DB_CYCLES-1; keep at least one bit.
  localparam int              DCW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DCW-1:0]  DB_MAX = DCW'(DB_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       cand_q;
  logic [DCW-1:0]   cnt_q;
  logic [1:0]       phase_q;
  logic [1:0]       diff_s;
  logic             stable_s;
  logic             accept_s;
  logic             fwd_s;
  logic             rev_s;
  logic             bad_s;
  logic [CNT_W-1:0] pos_d;
  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] pos_gray_q;
  logic             step_q;
  logic             dir_q;
  logic             err_q;
  logic [3:0]       err_cnt_q;

  // Position of a Gray phase along the up sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] phase_idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
    return b ^ {1'b0, b[CNT_W-1:1]};
  endfunction

  // Candidate has been seen on the synchronised input long enough.
  assign stable_s = (sync2_q == cand_q) && (cnt_q == DB_MAX);
  // Signed step distance modulo 4: 1 = forward, 3 = reverse, 2 = both bits flipped.
  assign diff_s   = phase_idx(cand_q) - phase_idx(phase_q);

  // Two-flop synchroniser for the asynchronous encoder phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {enc_a, enc_b};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: restart on any change, otherwise count up to the acceptance depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= 2'b00;
      cnt_q  <= {DCW{1'b0}};
    end else if (sync2_q != cand_q) begin
      cand_q <= sync2_q;
      cnt_q  <= {DCW{1'b0}};
    end else if (accept_s) begin
      cnt_q  <= cnt_q;
    end else if (cnt_q != DB_MAX) begin
      cnt_q  <= cnt_q + DCW'(1);
    end else begin
      cnt_q  <= cnt_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave INIT once the first stable phase has been learned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = stable_s ? ST_TRACK : ST_INIT;
      ST_TRACK: state_d = ST_TRACK;
      default:  state_d = ST_INIT;
    endcase
  end

  // FSM outputs: acceptance and classification of the accepted phase change.
  always_comb begin
    accept_s = 1'b0;
    fwd_s    = 1'b0;
    rev_s    = 1'b0;
    bad_s    = 1'b0;
    case (state_q)
      ST_INIT: begin
        accept_s = stable_s;
      end
      ST_TRACK: begin
        accept_s = stable_s && (cand_q != phase_q);
        if (accept_s) begin
          case (diff_s)
            2'd1:    fwd_s = 1'b1;
            2'd3:    rev_s = 1'b1;
            2'd2:    bad_s = 1'b1;
            default: bad_s = 1'b0;
          endcase
        end else begin
          fwd_s = 1'b0;
          rev_s = 1'b0;
          bad_s = 1'b0;
        end
      end
      default: accept_s = 1'b0;
    endcase
  end

  // Last accepted phase; updated on every accept, including illegal jumps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 2'b00;
    end else if (accept_s) begin
      phase_q <= cand_q;
    end else begin
      phase_q <= phase_q;
    end
  end

  // Next position: clear wins over a coincident step, arithmetic wraps.
  always_comb begin
    pos_d = pos_q;
    if (clr) begin
      pos_d = {CNT_W{1'b0}};
    end else if (fwd_s) begin
      pos_d = pos_q + CNT_W'(1);
    end else if (rev_s) begin
      pos_d = pos_q - CNT_W'(1);
    end else begin
      pos_d = pos_q;
    end
  end

  // Registered outputs: position (binary and Gray), pulses, direction, error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= {CNT_W{1'b0}};
      pos_gray_q <= {CNT_W{1'b0}};
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 4'd0;
    end else begin
      pos_q      <= pos_d;
      pos_gray_q <= bin2gray(pos_d);
      step_q     <= fwd_s | rev_s;
      err_q      <= bad_s;
      if (fwd_s) begin
        dir_q <= 1'b1;
      end else if (rev_s) begin
        dir_q <= 1'b0;
      end else begin
        dir_q <= dir_q;
      end
      if (clr) begin
        err_cnt_q <= 4'd0;
      end else if (bad_s && (err_cnt_q != 4'hF)) begin
        err_cnt_q <= err_cnt_q + 4'd1;
      end else begin
        err_cnt_q <= err_cnt_q;
      end
    end
  end

  assign pos      = pos_q;
  assign pos_gray = pos_gray_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule
